fifo_cc_flex: RTL
=================

Name: fifo_cc_flex

Overview:
- Single-clock synchronous FIFO; successor to the power-of-two fixed-flag FIFO in the stream layer.
- Adds:
  - arbitrary (non-power-of-two) depth
  - live occupancy count
  - programmable almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags
  - selectable first-word-fall-through (FWFT) or registered-read mode
- Sits between sc_stream producer/consumer ports inside translated SystemC modules.

Parameters:
- WIDTH, 64, data width in bits.
- DEPTH, 5, number of entries; any integer >= 2.
- FWFT, 1, 1 = dout shows head combinationally; 0 = dout registered, 1-cycle read latency.
- AF_LEVEL, 4, almost_full asserts when count >= AF_LEVEL; legal 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; legal 0..DEPTH-1.
- CW (localparam), $clog2(DEPTH+1), count width.

Ports:
- clk  in  1  rising-edge clock
- srst  in  1  synchronous reset, active-high
- din  in  WIDTH  write data
- wr_en  in  1  write request
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- dout  out  WIDTH  read data
- rd_en  in  1  read request
- empty  out  1  count == 0
- almost_empty  out  1  count <= AE_LEVEL
- count  out  CW  current occupancy
- err_clr  in  1  clears sticky error flags
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset: srst high at a clk edge sets:
  - wr_ptr = rd_ptr = count = 0; empty=1, full=0, almost_empty=1, almost_full=0
  - overflow = underflow = 0; dout = 0 when FWFT=0
  - Memory contents are not reset.
- Reset has priority over all other inputs. srst mid-operation discards all stored data in that cycle.
- Accept rules, evaluated on pre-edge flag state:
  - wr_acc = wr_en & !full
  - rd_acc = rd_en & !empty
- Full + simultaneous wr_en & rd_en: read accepted, write rejected, overflow set.
- Empty + simultaneous wr_en & rd_en: write accepted, read rejected, underflow set. No bypass.
- Write: mem[wr_ptr] <= din; wr_ptr advances.
- Read: rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. No modulo-power-of-two arithmetic; explicit compare.
- count update:
  - +1 on wr_acc & !rd_acc
  - -1 on rd_acc & !wr_acc
  - unchanged on both or neither
  - Never exceeds DEPTH or goes below 0.
- Flag derivation: all flags are combinational decodes of the registered count, so they change the cycle after the causing edge. Write-to-empty-deassert latency is 1 cycle.
- FWFT=1:
  - dout = mem[rd_ptr] combinationally.
  - Valid whenever empty=0; dout is don't-care while empty.
  - Data written into an empty FIFO appears on dout 1 cycle after the write edge.
- FWFT=0:
  - On rd_acc, dout <= mem[rd_ptr] at that edge, so data is available the cycle after the read.
  - dout holds its value otherwise, including while empty.
- Sticky errors:
  - overflow set on (wr_en & full); underflow set on (rd_en & empty).
  - Cleared by err_clr or srst.
  - If set and err_clr occur in the same cycle, set wins.
- Rejected requests never modify pointers, count or memory.

Optional Feature:
- Macro: FIFO_CC_FLEX_HWM_EN.
- When defined:
  - Adds output port hwm [CW-1:0], a high-water mark register holding the maximum count reached since the last srst or err_clr.
  - Updates at the edge after count increases: hwm <= max(hwm, next count).
  - Reset value is 0. err_clr loads it with the current count.
- When undefined: the port and register are absent, and behaviour is otherwise identical.

Test Plan:
- DEPTH=5, FWFT=1:
  - Write 0x11..0x55 on 5 consecutive cycles -> count 1..5, full=1 after 5th, almost_full=1 from count 4.
  - Read 5 -> dout sequence 0x11..0x55, then empty=1 and almost_empty=1 from count 1.
- Wrap: DEPTH=5; 3 writes, 3 reads, 7 more writes, read all -> data in order and pointers wrap past index 4, count never exceeds 5.
- Simultaneous: at count 3, wr_en=rd_en=1 for 4 cycles -> count stays 3, output order preserved. At full, both=1 -> count 4, overflow=1. At empty, both=1 -> count 1, underflow=1.
- Errors: wr_en while full -> overflow=1 and persists. err_clr pulse -> 0. err_clr together with a new overflow -> remains 1.
- FWFT=0: write 0xA5 then rd_en 1 cycle -> dout=0xA5 the cycle after the read edge, and holds when rd_en drops.
- Reset mid-operation: count=3, srst=1 for 1 cycle while wr_en=1 -> next cycle count=0, empty=1, write discarded. HWM build: hwm=0 after reset and 3 after refilling to 3.

Source files
------------

// File: rtl/fifo_cc_flex.sv
// Single-clock FIFO: arbitrary depth, occupancy count, programmable almost flags,
// sticky errors, FWFT or registered read. Define FIFO_CC_FLEX_HWM_EN to add the hwm port.
module fifo_cc_flex #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 5,
    parameter bit FWFT     = 1'b1,
    parameter int AF_LEVEL = 4,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    output logic             full,
    output logic             almost_full,
    output logic [WIDTH-1:0] dout,
    input  logic             rd_en,
    output logic             empty,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_CC_FLEX_HWM_EN
    ,
    output logic [CW-1:0]    hwm
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             wr_acc;
    logic             rd_acc;

    // Handshake: wr_en/rd_en are requests, !full/!empty are the matching readies;
    // a transfer happens only at a clk edge where request and ready are both high.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + CW'(1);
        else if (rd_acc && !wr_acc)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!srst && wr_acc)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
        end
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (srst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (rd_en && empty)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign dout = mem[rd_ptr];
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (srst)
                    dout <= '0;
                else if (rd_acc)
                    dout <= mem[rd_ptr];
            end
        end
    endgenerate

`ifdef FIFO_CC_FLEX_HWM_EN
    always_ff @(posedge clk) begin
        if (srst)
            hwm <= '0;
        else if (err_clr)
            hwm <= count;
        else if (count_nxt > hwm)
            hwm <= count_nxt;
    end
`endif

endmodule
